// File: rtl/sub_32_seq_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package sub_32_seq_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF   = 32;
    localparam int DIGIT_W_DEF = 8;
    localparam int NDIG_DEF    = WIDTH_DEF / DIGIT_W_DEF;

    // A single-digit configuration still needs a 1-bit counter.
    function automatic int cnt_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction
endpackage

// File: rtl/sub_32_seq_if.sv
// Operand/result handshake bundle between the ALU datapath and sub_32_seq.
interface sub_32_seq_if
    import sub_32_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             b_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, b_in, out_ready,
        input  in_ready, out_valid, d, b_out, ovf
    );

    modport slave (
        input  in_valid, a, b, b_in, out_ready,
        output in_ready, out_valid, d, b_out, ovf
    );
endinterface

// File: rtl/sub_32_seq_digit.sv
// Combinational W-bit subtractor slice: {o_bout, o_diff} = i_a - i_b - i_bin.
module sub_digit #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_bin,
    output logic [W-1:0] o_diff,
    output logic         o_bout
);
    logic [W:0] w_res;

    // One extra bit captures the borrow as the wrapped sign of the result.
    assign w_res            = {1'b0, i_a} - {1'b0, i_b} - {{W{1'b0}}, i_bin};
    assign {o_bout, o_diff} = w_res;
endmodule

// File: rtl/sub_32_seq.sv
// Digit-serial subtractor d = a - b - b_in, DIGIT_W bits per cycle with a registered borrow.
module sub_32_seq
    import sub_32_seq_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DIGIT_W = DIGIT_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    sub_32_seq_if.slave   s
);
    localparam int NDIG = WIDTH / DIGIT_W;
    localparam int CW   = cnt_w(NDIG);

    generate
        if (WIDTH % DIGIT_W != 0) begin : g_bad_digit
            $error("sub_32_seq: DIGIT_W must divide WIDTH evenly");
        end
    endgenerate

    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_d;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow, r_sa, r_sb;
    logic             r_in_ready, r_out_valid, r_bo, r_ovf;

    logic [DIGIT_W-1:0] w_diff;
    logic               w_bnext;
    logic [WIDTH-1:0]   w_d_shift;
    logic               w_last;

    sub_digit #(.W(DIGIT_W)) u_dig (
        .i_a    (r_a[DIGIT_W-1:0]),
        .i_b    (r_b[DIGIT_W-1:0]),
        .i_bin  (r_borrow),
        .o_diff (w_diff),
        .o_bout (w_bnext)
    );

    // Result digits enter at the MSB end so the LSB digit lands at the bottom after NDIG shifts.
    generate
        if (DIGIT_W == WIDTH) begin : g_one_digit
            assign w_d_shift = w_diff;
        end else begin : g_multi_digit
            assign w_d_shift = {w_diff, r_d[WIDTH-1:DIGIT_W]};
        end
    endgenerate

    assign w_last = (r_cnt == CW'(NDIG - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_borrow    <= 1'b0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_bo        <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (s.in_valid && r_in_ready) begin
                        r_a        <= s.a;
                        r_b        <= s.b;
                        r_borrow   <= s.b_in;
                        r_sa       <= s.a[WIDTH-1];
                        r_sb       <= s.b[WIDTH-1];
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_BUSY;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_BUSY: begin
                    r_d      <= w_d_shift;
                    r_a      <= r_a >> DIGIT_W;
                    r_b      <= r_b >> DIGIT_W;
                    r_borrow <= w_bnext;
                    if (w_last) begin
                        r_bo        <= w_bnext;
                        // Sign of the final d is the top bit of the last digit.
                        r_ovf       <= (r_sa != r_sb) && (w_diff[DIGIT_W-1] != r_sa);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (s.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s.in_ready  = r_in_ready;
    assign s.out_valid = r_out_valid;
    assign s.d         = r_d;
    assign s.b_out     = r_bo;
    assign s.ovf       = r_ovf;
endmodule

// File: tb/tb_sub_32_seq.sv
// Self-checking bench for sub_32_seq: vector table, random ops, backpressure and mid-op reset.
module tb_sub_32_seq;
    localparam int W    = 32;
    localparam int NDIG = 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        res_t         exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sub_32_seq_if #(.WIDTH(W)) bus ();

    sub_32_seq #(.WIDTH(W), .DIGIT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t sb_q[$];
    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] r;
        res_t       o;
        r     = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        o.d   = r[W-1:0];
        o.bo  = r[W];
        o.ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        return o;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                input logic [W-1:0] d, input logic bo, input logic ovf);
        vec_t v;
        v.a = a; v.b = b; v.bin = bin;
        v.exp.d = d; v.exp.bo = bo; v.exp.ovf = ovf;
        return v;
    endfunction

    // Waits for in_ready, presents operands for one accept edge, records the expected result.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input res_t e);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", bus.in_ready, 1);
        bus.a        = a;
        bus.b        = b;
        bus.b_in     = bin;
        bus.in_valid = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Called on the negedge right after the accept edge; n then counts cycles to out_valid.
    task automatic collect(input string name);
        int   n = 0;
        res_t e;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_out_valid"}, bus.out_valid, 1);
        chk({name, "_latency"}, n, NDIG);
        chk({name, "_sb_nonempty"}, (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({name, "_d"}, bus.d, e.d);
            chk({name, "_b_out"}, bus.b_out, e.bo);
            chk({name, "_ovf"}, bus.ovf, e.ovf);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rbin;

        vecs[0] = mk(32'd512,        32'd256,        1'b0, 32'd256,        1'b0, 1'b0);
        vecs[1] = mk(32'd39,         32'd35,         1'b1, 32'd3,          1'b0, 1'b0);
        vecs[2] = mk(32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0);
        vecs[3] = mk(32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF,  1'b0, 1'b1);
        vecs[4] = mk(32'd0,          32'd0,          1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0);
        vecs[5] = mk(32'h1234_5678,  32'h1234_5678,  1'b0, 32'd0,          1'b0, 1'b0);
        vecs[6] = mk(32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  1'b1, 1'b1);
        vecs[7] = mk(32'hFFFF_FFFF,  32'd0,          1'b1, 32'hFFFF_FFFE,  1'b0, 1'b0);
        vecs[8] = mk(32'h0000_0100,  32'h0000_00FF,  1'b0, 32'd1,          1'b0, 1'b0);

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.b_in      = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_d", bus.d, 0);
        chk("rst_b_out", bus.b_out, 0);
        chk("rst_ovf", bus.ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);

        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp);
            collect($sformatf("vec%0d", i));
            @(negedge clk);
            chk($sformatf("vec%0d_done_exit", i), {bus.out_valid, bus.in_ready}, 2'b01);
        end

        for (int i = 0; i < 6; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rbin = 1'($urandom_range(0, 1));
            send(ra, rb, rbin, model(ra, rb, rbin));
            collect($sformatf("rnd%0d", i));
            @(negedge clk);
        end

        // Backpressure: result must hold while a second op waits on in_valid.
        bus.out_ready = 1'b0;
        send(32'd10, 32'd3, 1'b0, model(32'd10, 32'd3, 1'b0));
        bus.a        = 32'd100;
        bus.b        = 32'd1;
        bus.b_in     = 1'b0;
        bus.in_valid = 1'b1;
        collect("bp1");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_d", i), bus.d, 32'd7);
            chk($sformatf("bp_hold%0d_rdy_vld", i), {bus.in_ready, bus.out_valid}, 2'b01);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_idle", {bus.out_valid, bus.in_ready}, 2'b01);
        chk("bp_d_kept", bus.d, 32'd7);
        sb_q.push_back(model(32'd100, 32'd1, 1'b0));
        @(negedge clk);
        bus.in_valid = 1'b0;
        collect("bp2");
        @(negedge clk);

        // Asynchronous reset during the second BUSY cycle discards the op.
        send(32'h1234_5678, 32'd1, 1'b0, model(32'h1234_5678, 32'd1, 1'b0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_d", bus.d, 0);
        chk("midrst_flags", {bus.in_ready, bus.out_valid, bus.b_out, bus.ovf}, 4'b0000);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", bus.in_ready, 1);
        send(32'd5, 32'd5, 1'b0, model(32'd5, 32'd5, 1'b0));
        collect("after_rst");
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
